// File: rtl/lcd_write_sequencer.sv
// Write-only HD44780 bus sequencer: power-up init, then single host byte writes
// over a req/ack handshake with EN/RS/DATA setup, pulse, hold and completion delays.
module lcd_write_sequencer #(
  parameter int PWRUP_DLY_CYC = 750000,
  parameter int SETUP_CYC     = 4,
  parameter int EN_PULSE_CYC  = 16,
  parameter int CMD_DLY_CYC   = 2500,
  parameter int CLR_DLY_CYC   = 100000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iREQ,
  input  logic       iRS,
  input  logic [7:0] iDATA,
  output logic       oREADY,
  output logic       oACK,
  inout  wire  [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  // state     | meaning
  // PWRUP     | waiting for the panel supply to settle after reset
  // INIT_LOAD | placing the next init command on RS/DATA
  // SETUP     | RS/DATA stable, EN low, before the strobe
  // EN_HI     | EN strobe high
  // HOLD      | EN low again, RS/DATA held
  // WAIT      | panel busy executing the written byte
  // IDLE      | init complete, host request may be accepted
  typedef enum logic [2:0] {
    S_PWRUP, S_INIT_LOAD, S_SETUP, S_EN_HI, S_HOLD, S_WAIT, S_IDLE
  } state_t;

  localparam int MAX_A   = (PWRUP_DLY_CYC > CLR_DLY_CYC) ? PWRUP_DLY_CYC : CLR_DLY_CYC;
  localparam int MAX_B   = (CMD_DLY_CYC > EN_PULSE_CYC) ? CMD_DLY_CYC : EN_PULSE_CYC;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_DLY = (MAX_C > SETUP_CYC) ? MAX_C : SETUP_CYC;
  localparam int CNT_W   = $clog2(MAX_DLY + 1);

  // Counter runs from 0 up to (cycles - 1); a state lasts exactly its cycle count.
  localparam logic [CNT_W-1:0] PWRUP_LIM = CNT_W'(PWRUP_DLY_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LIM = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LIM    = CNT_W'(EN_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LIM   = CNT_W'(CMD_DLY_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LIM   = CNT_W'(CLR_DLY_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] lim;
  logic [CNT_W-1:0] wait_lim;
  logic             timer_done;
  logic [1:0]       init_idx_q;
  logic             init_done_q;
  logic             rs_q;
  logic [7:0]       data_q;
  logic             ack_q;
  logic             accept;
  logic [7:0]       init_byte;

  always_comb begin
    init_byte = 8'h38;
    case (init_idx_q)
      2'd0: init_byte = 8'h38;
      2'd1: init_byte = 8'h0C;
      2'd2: init_byte = 8'h01;
      2'd3: init_byte = 8'h06;
      default: init_byte = 8'h38;
    endcase
  end

  // Clear and return-home need the long completion delay.
  assign wait_lim = (!rs_q && (data_q[7:2] == 6'd0)) ? CLR_LIM : CMD_LIM;

  always_comb begin
    lim = '0;
    case (state_q)
      S_PWRUP: lim = PWRUP_LIM;
      S_SETUP: lim = SETUP_LIM;
      S_EN_HI: lim = EN_LIM;
      S_HOLD:  lim = SETUP_LIM;
      S_WAIT:  lim = wait_lim;
      default: lim = '0;
    endcase
  end

  assign timer_done = (cnt_q == lim);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_PWRUP:     if (timer_done) state_d = S_INIT_LOAD;
      S_INIT_LOAD: state_d = S_SETUP;
      S_SETUP:     if (timer_done) state_d = S_EN_HI;
      S_EN_HI:     if (timer_done) state_d = S_HOLD;
      S_HOLD:      if (timer_done) state_d = S_WAIT;
      S_WAIT: begin
        if (timer_done) begin
          if (init_done_q || (init_idx_q == 2'd3)) state_d = S_IDLE;
          else                                     state_d = S_INIT_LOAD;
        end
      end
      S_IDLE: begin
        if (iREQ) begin
          accept  = 1'b1;
          state_d = S_SETUP;
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= S_PWRUP;
      cnt_q       <= '0;
      init_idx_q  <= 2'd0;
      init_done_q <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      ack_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      // Reload on every state entry; IDLE holds at zero so the counter never wraps.
      if ((state_d != state_q) || (state_q == S_IDLE)) cnt_q <= '0;
      else                                             cnt_q <= cnt_q + 1'b1;
      ack_q <= accept;
      if (accept) begin
        rs_q   <= iRS;
        data_q <= iDATA;
      end else if (state_q == S_INIT_LOAD) begin
        rs_q   <= 1'b0;
        data_q <= init_byte;
      end
      if ((state_q == S_WAIT) && timer_done && !init_done_q) begin
        if (init_idx_q == 2'd3) init_done_q <= 1'b1;
        else                    init_idx_q  <= init_idx_q + 2'd1;
      end
    end
  end

  // EN decodes straight from the state register so reset drops it asynchronously.
  assign LCD_EN   = (state_q == S_EN_HI);
  assign oREADY   = (state_q == S_IDLE);
  assign oACK     = ack_q;
  assign LCD_RS   = rs_q;
  assign LCD_DATA = data_q;
  assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: expected LCD writes are queued as stimulus is
// driven and checked against EN strobes observed on the pins.
module tb_lcd_write_sequencer;
  localparam int PW = 100, SU = 2, EP = 4, CMD = 20, CLR = 50;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         w;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, ack, lcd_rw, lcd_en, lcd_rs;
  wire  [7:0] lcd_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  wr_t sb[$];

  lcd_write_sequencer #(
    .PWRUP_DLY_CYC(PW), .SETUP_CYC(SU), .EN_PULSE_CYC(EP),
    .CMD_DLY_CYC(CMD), .CLR_DLY_CYC(CLR)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iREQ(req), .iRS(rs), .iDATA(data),
    .oREADY(ready), .oACK(ack), .LCD_DATA(lcd_data), .LCD_RW(lcd_rw),
    .LCD_EN(lcd_en), .LCD_RS(lcd_rs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  function automatic int exp_wait(input logic r, input logic [7:0] d);
    return (!r && (d[7:2] == 6'd0)) ? CLR : CMD;
  endfunction

  // Pin monitor: pops one expected write per EN strobe, checks stability, width, gaps.
  logic       in_pulse = 1'b0, gap_on = 1'b0;
  int         width = 0, gap = 0, gap_w = 0;
  logic       cur_rs = 1'b0;
  logic [7:0] cur_data = 8'h00;
  logic [8:0] prev1 = '0, prev2 = '0;
  wr_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_pulse = 1'b0;
      gap_on   = 1'b0;
      prev1    = '0;
      prev2    = '0;
    end else begin
      if (lcd_en && !in_pulse) begin
        if (gap_on) begin
          total++;
          if (gap !== gap_w + 3 + SU) begin
            bad++;
            $display("FAIL init_gap: got %0d cycles want %0d", gap, gap_w + 3 + SU);
          end
        end
        gap_on = 1'b0; in_pulse = 1'b1; width = 1;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse: rs=%0b data=%02h with nothing expected", lcd_rs, lcd_data);
        end else begin
          e = sb.pop_front();
          cur_rs = e.rs; cur_data = e.data; gap_w = e.w;
          if ({lcd_rs, lcd_data} !== {e.rs, e.data}) begin
            bad++;
            $display("FAIL write_value: got rs=%0b data=%02h want rs=%0b data=%02h",
                     lcd_rs, lcd_data, e.rs, e.data);
          end
        end
        total++;
        if (prev1 !== {lcd_rs, lcd_data} || prev2 !== {lcd_rs, lcd_data}) begin
          bad++;
          $display("FAIL setup_stable: got %03h,%03h before EN want %03h", prev2, prev1, {lcd_rs, lcd_data});
        end
      end else if (lcd_en) begin
        width++;
        total++;
        if ({lcd_rs, lcd_data} !== {cur_rs, cur_data}) begin
          bad++;
          $display("FAIL en_stable: got %03h want %03h", {lcd_rs, lcd_data}, {cur_rs, cur_data});
        end
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        total++;
        if (width !== EP) begin
          bad++;
          $display("FAIL en_width: got %0d want %0d", width, EP);
        end
        gap_on = 1'b1; gap = 1;
        total++;
        if ({lcd_rs, lcd_data} !== {cur_rs, cur_data}) begin
          bad++;
          $display("FAIL hold_stable: got %03h want %03h", {lcd_rs, lcd_data}, {cur_rs, cur_data});
        end
      end else if (gap_on) begin
        if (ready) begin
          gap_on = 1'b0;
          total++;
          if (gap !== SU + gap_w) begin
            bad++;
            $display("FAIL done_gap: got %0d cycles want %0d", gap, SU + gap_w);
          end
        end else begin
          gap++;
          if (gap <= SU) begin
            total++;
            if ({lcd_rs, lcd_data} !== {cur_rs, cur_data}) begin
              bad++;
              $display("FAIL hold_stable: got %03h want %03h", {lcd_rs, lcd_data}, {cur_rs, cur_data});
            end
          end
        end
      end
      prev2 = prev1;
      prev1 = {lcd_rs, lcd_data};
    end
  end

  task automatic push_wr(input logic r, input logic [7:0] d);
    wr_t x;
    x.rs = r; x.data = d; x.w = exp_wait(r, d);
    sb.push_back(x);
  endtask

  // Releases reset and follows the power-up wait and four init writes to IDLE.
  task automatic run_init(input logic poke);
    int   n;
    logic seen_ready;
    sb.delete();
    push_wr(1'b0, 8'h38); push_wr(1'b0, 8'h0C); push_wr(1'b0, 8'h01); push_wr(1'b0, 8'h06);
    @(negedge clk); #2 rst_n = 1'b1;
    n = 0; seen_ready = 1'b0;
    while (n < 1000) begin
      @(negedge clk); n++;
      if (ready) seen_ready = 1'b1;
      if (poke) begin
        total++;
        if (ack !== 1'b0) begin bad++; $display("FAIL init_ack: got oACK=%0b want 0", ack); end
      end
      if (lcd_en) break;
      if (poke) begin req = (n % 7 == 3); rs = 1'($urandom); data = 8'($urandom); end
    end
    total++;
    if (n !== PW + 1 + SU) begin bad++; $display("FAIL first_en: got %0d cycles want %0d", n, PW + 1 + SU); end
    total++;
    if (seen_ready !== 1'b0) begin bad++; $display("FAIL pwrup_ready: got oREADY=1 want 0"); end
    n = 0;
    while (!ready && n < 2000) begin
      @(negedge clk); n++;
      if (poke) begin
        total++;
        if (ack !== 1'b0) begin bad++; $display("FAIL init_ack: got oACK=%0b want 0", ack); end
        if (ready) req = 1'b0;
        else begin req = (n % 5 == 1); rs = 1'($urandom); data = 8'($urandom); end
      end
    end
    req = 1'b0;
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL init_done: got oREADY=%0b want 1 (timeout)", ready); end
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL init_writes: got %0d unseen want 0", sb.size()); end
  endtask

  task automatic wait_ready(input int bound);
    int n;
    n = 0;
    while (!ready && n < bound) begin @(negedge clk); n++; end
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL ready_timeout: got oREADY=%0b want 1", ready); end
  endtask

  task automatic write_byte(input logic r, input logic [7:0] d, output int ack_cyc);
    wait_ready(1000);
    req = 1'b1; rs = r; data = d;
    push_wr(r, d);
    @(negedge clk);
    ack_cyc = cyc;
    total++;
    if (ack !== 1'b1 || ready !== 1'b0) begin
      bad++; $display("FAIL accept: got oACK=%0b oREADY=%0b want 1 0", ack, ready);
    end
    req = 1'b0; rs = ~r; data = ~d;
    @(negedge clk);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL ack_width: got oACK=%0b want 0", ack); end
  endtask

  task automatic timed_write(input logic r, input logic [7:0] d);
    int n, t;
    write_byte(r, d, t);
    n = 1;
    while (!ready && n < 1000) begin @(negedge clk); n++; end
    total++;
    if (n !== 2 * SU + EP + exp_wait(r, d)) begin
      bad++; $display("FAIL write_time %02h: got %0d cycles want %0d", d, n, 2 * SU + EP + exp_wait(r, d));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({lcd_en, lcd_rs, lcd_rw, ready, ack} !== 5'b0 || lcd_data !== 8'h00) begin
      bad++; $display("FAIL reset_values: got en=%0b rs=%0b rw=%0b rdy=%0b ack=%0b data=%02h want all 0",
                      lcd_en, lcd_rs, lcd_rw, ready, ack, lcd_data);
    end
    run_init(1'b0);
  endtask

  task automatic test_single_write();
    timed_write(1'b1, 8'h41);
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL single_write: got %0d unseen want 0", sb.size()); end
  endtask

  task automatic test_held_req();
    int t0, n;
    write_byte(1'b1, 8'h55, t0);
    repeat (5) @(negedge clk);
    req = 1'b1; rs = 1'b1; data = 8'h42;
    push_wr(1'b1, 8'h42);
    n = 0;
    while (!ack && n < 200) begin @(negedge clk); n++; end
    total++;
    if (cyc - t0 !== 2 * SU + EP + CMD + 1) begin
      bad++; $display("FAIL ack_spacing: got %0d cycles want %0d", cyc - t0, 2 * SU + EP + CMD + 1);
    end
    req = 1'b0; rs = 1'b0; data = 8'h00;
    @(negedge clk);
    wait_ready(1000);
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL held_req: got %0d unseen want 0", sb.size()); end
  endtask

  task automatic test_cmd_waits();
    logic [8:0] vec [6];
    vec = '{9'h001, 9'h002, 9'h080, 9'h101, 9'h003, 9'h004};
    for (int i = 0; i < 6; i++) timed_write(vec[i][8], vec[i][7:0]);
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL cmd_waits: got %0d unseen want 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    int t, n;
    write_byte(1'b1, 8'h5A, t);
    n = 0;
    while (!lcd_en && n < 50) begin @(negedge clk); n++; end
    total++;
    if (lcd_en !== 1'b1) begin bad++; $display("FAIL mid_en: got LCD_EN=%0b want 1", lcd_en); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (lcd_en !== 1'b0 || ready !== 1'b0 || lcd_rs !== 1'b0 || lcd_data !== 8'h00) begin
      bad++; $display("FAIL async_reset: got en=%0b rdy=%0b rs=%0b data=%02h want 0 0 0 00",
                      lcd_en, ready, lcd_rs, lcd_data);
    end
    repeat (3) @(negedge clk);
    run_init(1'b0);
  endtask

  task automatic test_req_during_init();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    run_init(1'b1);
    timed_write(1'b1, 8'h7E);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_held_req();
    test_cmd_waits();
    test_reset_mid();
    test_req_during_init();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
